// File: rtl/vertical_counter_generator.sv
// vertical_counter_generator: VGA line counter with VSYNC, active flag, /SCALE row index and frame pulse.
// Optional macro VER_FRAME_CNT_EN adds an 8-bit frame counter output frame_cnt.
module vertical_counter_generator #(
   parameter int V_TOTAL     = 521,
   parameter int V_SYNC      = 2,
   parameter int V_ACT_START = 31,
   parameter int V_ACT       = 480,
   parameter int SCALE       = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       new_line,
   output logic [9:0] ver_cnt,
   output logic [6:0] scl_ver_cnt,
   output logic       VSYNC,
   output logic       v_active,
   output logic       new_frame
`ifdef VER_FRAME_CNT_EN
   ,
   output logic [7:0] frame_cnt
`endif
);
   localparam logic [9:0] LAST      = 10'(V_TOTAL - 1);
   localparam logic [9:0] SYNC_END  = 10'(V_SYNC);
   localparam logic [9:0] ACT_FIRST = 10'(V_ACT_START);
   localparam logic [9:0] ACT_LAST  = 10'(V_ACT_START + V_ACT - 1);
   localparam logic [2:0] SUB_LAST  = 3'(SCALE - 1);

   logic [9:0] ver_cnt_q, ver_cnt_d, line_nxt;
   logic [6:0] scl_q, scl_d;
   logic [2:0] int_cnt_q, int_cnt_d;
   logic       vsync_q, vsync_d, v_active_q, v_active_d, new_frame_q, new_frame_d;
   logic       wrap, hold, restart, roll;
`ifdef VER_FRAME_CNT_EN
   logic [7:0] frame_cnt_q, frame_cnt_d;
`endif

   always_comb begin
      wrap        = ver_cnt_q == LAST;
      line_nxt    = wrap ? '0 : ver_cnt_q + 10'd1;
      ver_cnt_d   = new_line ? line_nxt : ver_cnt_q;
      new_frame_d = new_line && wrap;
      vsync_d     = ver_cnt_q >= SYNC_END;
      v_active_d  = (ver_cnt_d >= ACT_FIRST) && (ver_cnt_d <= ACT_LAST);
      // row index freezes at its last value through the trailing blanking lines
      hold        = !new_line || (line_nxt > ACT_LAST);
      restart     = line_nxt <= ACT_FIRST;
      roll        = int_cnt_q == SUB_LAST;
      int_cnt_d   = hold ? int_cnt_q : (restart || roll) ? '0 : int_cnt_q + 3'd1;
      scl_d       = hold ? scl_q : restart ? '0 : roll ? scl_q + 7'd1 : scl_q;
`ifdef VER_FRAME_CNT_EN
      frame_cnt_d = frame_cnt_q + 8'(new_frame_d);
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ver_cnt_q   <= '0;
         scl_q       <= '0;
         int_cnt_q   <= '0;
         vsync_q     <= 1'b0;
         v_active_q  <= 1'b0;
         new_frame_q <= 1'b0;
`ifdef VER_FRAME_CNT_EN
         frame_cnt_q <= '0;
`endif
      end else begin
         ver_cnt_q   <= ver_cnt_d;
         scl_q       <= scl_d;
         int_cnt_q   <= int_cnt_d;
         vsync_q     <= vsync_d;
         v_active_q  <= v_active_d;
         new_frame_q <= new_frame_d;
`ifdef VER_FRAME_CNT_EN
         frame_cnt_q <= frame_cnt_d;
`endif
      end
   end

   assign ver_cnt     = ver_cnt_q;
   assign scl_ver_cnt = scl_q;
   assign VSYNC       = vsync_q;
   assign v_active    = v_active_q;
   assign new_frame   = new_frame_q;
`ifdef VER_FRAME_CNT_EN
   assign frame_cnt   = frame_cnt_q;
`endif
endmodule

// File: tb/tb_vertical_counter_generator.sv
// tb_vertical_counter_generator: random new_line traffic checked against a line-number reference model.
module tb_vertical_counter_generator;
   logic       clk = 1'b0, reset = 1'b1, new_line = 1'b0;
   logic [9:0] ver_cnt;
   logic [6:0] scl_ver_cnt;
   logic       VSYNC, v_active, new_frame;
`ifdef VER_FRAME_CNT_EN
   logic [7:0] frame_cnt;
`endif
   int total = 0, bad = 0;
   int line_m = 0, frames_m = 0;
   logic vs_m = 1'b0, nf_m = 1'b0;

   vertical_counter_generator dut (
      .clk(clk), .reset(reset), .new_line(new_line), .ver_cnt(ver_cnt),
      .scl_ver_cnt(scl_ver_cnt), .VSYNC(VSYNC), .v_active(v_active), .new_frame(new_frame)
`ifdef VER_FRAME_CNT_EN
      , .frame_cnt(frame_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s line=%0d got=%0d exp=%0d", tag, line_m, got, exp);
      end
   endtask

   function automatic int scl_of(input int l);
      return l < 31 ? 0 : l <= 510 ? (l - 31) / 5 : 95;
   endfunction

   function automatic logic act_of(input int l);
      return l >= 31 && l <= 510;
   endfunction

   task automatic check_all();
      chk("ver_cnt", 32'(ver_cnt), line_m);
      chk("scl_ver_cnt", 32'(scl_ver_cnt), scl_of(line_m));
      chk("v_active", 32'(v_active), 32'(act_of(line_m)));
      chk("VSYNC", 32'(VSYNC), 32'(vs_m));
      chk("new_frame", 32'(new_frame), 32'(nf_m));
`ifdef VER_FRAME_CNT_EN
      chk("frame_cnt", 32'(frame_cnt), frames_m % 256);
`endif
   endtask

   task automatic step(input logic nl);
      new_line = nl;
      @(posedge clk);
      vs_m = line_m >= 2;
      nf_m = nl && line_m == 520;
      if (nl) line_m = (line_m + 1) % 521;
      if (nf_m) frames_m++;
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      new_line = 1'b0;
      #2 reset = 1'b1;
      #1 line_m = 0; vs_m = 1'b0; nf_m = 1'b0; frames_m = 0;
      check_all();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #2 check_all();
      @(negedge clk);
      reset = 1'b0;
      check_all();
      for (int i = 0; i < 50; i++) step(1'b0);
      for (int i = 0; i < 4000; i++) step($urandom_range(0, 3) != 0);
      do_reset();
      for (int i = 0; i < 300; i++) step(1'b1);
      chk("b2b_300", 32'(ver_cnt), 300);
      do_reset();
      step(1'b1);
      step(1'b1);
      chk("after_reset_ver2", 32'(ver_cnt), 2);
      step(1'b0);
      chk("after_reset_vsync", 32'(VSYNC), 1);
`ifdef VER_FRAME_CNT_EN
      do_reset();
      for (int i = 0; i < 257 * 521; i++) step(1'b1);
      chk("frame_cnt_257", 32'(frame_cnt), 1);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
